// File: rtl/led_scan_driver_if.sv
// CPU-side display register / board-pin bundle for led_scan_driver.
// master = display register owner, slave = the scan driver.
interface led_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    Enable;
  logic                    Load;
  logic [4*NUM_DIGITS-1:0] Value;
  logic [NUM_DIGITS-1:0]   DPIn;
  logic                    SegA, SegB, SegC, SegD, SegE, SegF, SegG;
  logic                    DP;
  logic [NUM_DIGITS-1:0]   nDigit;
  logic                    FrameDone;

  modport master (
    output Enable, Load, Value, DPIn,
    input  SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP, nDigit, FrameDone
  );

  modport slave (
    input  Enable, Load, Value, DPIn,
    output SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP, nDigit, FrameDone
  );
endinterface

// File: rtl/led_scan_driver.sv
// Multiplexed common-cathode 7-segment scan driver with blanking guard and
// frame-atomic display update. Optional leading-zero blanking: LED_ZERO_SUPPRESS_EN.
module led_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 1,
  parameter int BLANK_TICKS = 1
) (
  input logic               Clock,
  input logic               Reset,
  led_scan_driver_if.slave  bus
);
  localparam int TICK_MAX = (DIGIT_TICKS > BLANK_TICKS) ?
                            ((DIGIT_TICKS > 2) ? DIGIT_TICKS : 2) :
                            ((BLANK_TICKS > 2) ? BLANK_TICKS : 2);
  localparam int TW = $clog2(TICK_MAX);
  localparam int IW = $clog2((NUM_DIGITS > 2) ? NUM_DIGITS : 2);
  localparam logic [TW-1:0] DIGIT_LAST = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} stateT;
  localparam stateT ENTRY = (BLANK_TICKS > 0) ? BLANK : DRIVE;

  stateT                   state, stateNext;
  logic [TW-1:0]           tick, tickNext;
  logic [IW-1:0]           idx, idxNext;
  logic [4*NUM_DIGITS-1:0] shadowVal, pendVal;
  logic [NUM_DIGITS-1:0]   shadowDp, pendDp;
  logic                    pendingValid;
  logic                    frameEnd;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [NUM_DIGITS-1:0]   digitNext;
  logic [6:0]              segNext;
  logic                    dpNext;

  function automatic logic [6:0] hexDecode(input logic [3:0] n);
    logic [6:0] s;  // {A,B,C,D,E,F,G}
    s = '0;
    case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      4'hF: s = 7'b1000111;
      default: s = '0;
    endcase
    return s;
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      tick  <= '0;
      idx   <= '0;
    end else begin
      state <= stateNext;
      tick  <= tickNext;
      idx   <= idxNext;
    end
  end

  always_comb begin
    stateNext = state;
    tickNext  = tick + 1'b1;
    idxNext   = idx;
    case (state)
      IDLE: begin
        tickNext = '0;
        if (bus.Enable) stateNext = ENTRY;
      end
      BLANK: if (tick == BLANK_LAST) begin
        stateNext = DRIVE;
        tickNext  = '0;
      end
      DRIVE: if (tick == DIGIT_LAST) begin
        stateNext = ENTRY;
        tickNext  = '0;
        idxNext   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      default: stateNext = IDLE;
    endcase
    if (!bus.Enable) begin
      stateNext = IDLE;
      tickNext  = '0;
      idxNext   = '0;
    end
  end

  assign frameEnd = (state == DRIVE) && bus.Enable && (tick == DIGIT_LAST) && (idx == IDX_LAST);

`ifdef LED_ZERO_SUPPRESS_EN
  always_comb begin
    logic allZero;
    suppress = '0;
    allZero  = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      allZero = allZero && (shadowVal[(NUM_DIGITS-1-k)*4 +: 4] == 4'h0);
      suppress[NUM_DIGITS-1-k] = allZero;
    end
  end
`else
  assign suppress = '0;
`endif

  // Outputs follow the registered state, so they lag the FSM by one edge.
  always_comb begin
    digitNext = '1;
    segNext   = '0;
    dpNext    = 1'b0;
    if (state == DRIVE) begin
      digitNext[idx] = 1'b0;
      segNext        = suppress[idx] ? 7'b0 : hexDecode(shadowVal[idx*4 +: 4]);
      dpNext         = shadowDp[idx];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      {bus.SegA, bus.SegB, bus.SegC, bus.SegD, bus.SegE, bus.SegF, bus.SegG} <= '0;
      bus.DP        <= 1'b0;
      bus.nDigit    <= '1;
      bus.FrameDone <= 1'b0;
    end else begin
      {bus.SegA, bus.SegB, bus.SegC, bus.SegD, bus.SegE, bus.SegF, bus.SegG} <= segNext;
      bus.DP        <= dpNext;
      bus.nDigit    <= digitNext;
      bus.FrameDone <= frameEnd;
    end
  end

  // While dark or at a frame boundary the shadow may change freely; a Load
  // arriving on the same edge overrides any older pending value.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shadowVal    <= '0;
      shadowDp     <= '0;
      pendVal      <= '0;
      pendDp       <= '0;
      pendingValid <= 1'b0;
    end else if ((state == IDLE) || frameEnd) begin
      if (bus.Load) begin
        shadowVal    <= bus.Value;
        shadowDp     <= bus.DPIn;
        pendingValid <= 1'b0;
      end else if (pendingValid) begin
        shadowVal    <= pendVal;
        shadowDp     <= pendDp;
        pendingValid <= 1'b0;
      end
    end else if (bus.Load) begin
      pendVal      <= bus.Value;
      pendDp       <= bus.DPIn;
      pendingValid <= 1'b1;
    end
  end
endmodule
